reg_writeback: RTL and testbench

- Write-side companion to the pipeline register file: collects results from the ALU path and the load path and serialises them onto the file's single write port (reg_write, rd, write_data).
- Buffers results in a small FIFO so that late load returns and back-to-back ALU results never collide.
- Publishes a per-register pending mask so that hazard logic in ID can stall reads of registers with writes still in flight.

---
 rtl/wb_pkg.sv | 10 +
 rtl/wb_fifo.sv | 53 +++++
 rtl/reg_writeback.sv | 78 +++++++
 tb/tb_reg_writeback.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// wb_pkg: shared widths, the zero-register index and the queued write entry type
package wb_pkg;
    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;
    localparam logic [ADDR_W-1:0] ZERO_REG = 5'd0;
    typedef struct packed {
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: synchronous entry FIFO with flush, occupancy count and per-slot valid/rd view
// Ports: clk, rst (async active-low), flush (clear pointers), push/din (enqueue),
//        pop (dequeue when non-empty), head (oldest entry), count (occupancy),
//        valid (slot holds a queued entry), ent_rd (destination index of every slot)
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CW = $clog2(DEPTH) + 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic                          push,
    input  wb_entry_t                     din,
    input  logic                          pop,
    output wb_entry_t                     head,
    output logic [CW-1:0]                 count,
    output logic [DEPTH-1:0]              valid,
    output logic [DEPTH-1:0][ADDR_W-1:0]  ent_rd
);
    localparam int PW = CW - 1;
    wb_entry_t mem [DEPTH];
    logic [PW-1:0] wp, rp;
    logic do_pop;
    assign do_pop = pop && count != '0;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wp <= '0;
            rp <= '0;
            count <= '0;
        end else if (flush) begin
            wp <= '0;
            rp <= '0;
            count <= '0;
        end else begin
            if (push) wp <= wp + PW'(1);
            if (do_pop) rp <= rp + PW'(1);
            count <= count + CW'(push) - CW'(do_pop);
        end
    end
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wp] <= din;
    end
    assign head = mem[rp];
    // a slot is live when its distance from the read pointer is below the occupancy
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            valid[i] = {1'b0, PW'(i) - rp} < count;
            ent_rd[i] = mem[i].rd;
        end
    end
endmodule

// File: rtl/reg_writeback.sv
// reg_writeback: arbitrates load/ALU results into a FIFO and serialises them onto the register-file write port
// Ports: clk, rst (async active-low), flush (drop queued entries),
//        ld_* / alu_* (valid-ready result inputs, loads win), reg_write/rd/write_data (registered write port),
//        pending_mask (registers with writes in flight), empty (nothing queued or issuing), write_count (committed writes)
module reg_writeback
    import wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              ld_valid,
    input  logic [ADDR_W-1:0] ld_rd,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_ready,
    input  logic              alu_valid,
    input  logic [ADDR_W-1:0] alu_rd,
    input  logic [DATA_W-1:0] alu_data,
    output logic              alu_ready,
    output logic              reg_write,
    output logic [ADDR_W-1:0] rd,
    output logic [DATA_W-1:0] write_data,
    output logic [31:0]       pending_mask,
    output logic              empty,
    output logic [31:0]       write_count
);
    localparam int CW = $clog2(DEPTH) + 1;
    wb_entry_t din, head;
    logic [CW-1:0] count;
    logic [DEPTH-1:0] valid;
    logic [DEPTH-1:0][ADDR_W-1:0] ent_rd;
    logic full, take_ld, take_alu, push, issue;
    assign full = count == CW'(DEPTH);
    assign ld_ready = !full && !flush;
    assign alu_ready = ld_ready && !ld_valid;
    assign take_ld = ld_valid && ld_ready;
    assign take_alu = alu_valid && alu_ready;
    assign din = take_ld ? {ld_rd, ld_data} : {alu_rd, alu_data};
    // writes to r0 finish the handshake but are dropped here
    assign push = (take_ld || take_alu) && din.rd != ZERO_REG;
    // the head is popped even under flush, but only issued when not flushing
    assign issue = count != '0 && !flush;
    wb_fifo #(.DEPTH(DEPTH), .CW(CW)) u_fifo (
        .clk(clk),
        .rst(rst),
        .flush(flush),
        .push(push),
        .din(din),
        .pop(1'b1),
        .head(head),
        .count(count),
        .valid(valid),
        .ent_rd(ent_rd)
    );
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            reg_write <= 1'b0;
            rd <= '0;
            write_data <= '0;
            write_count <= '0;
        end else begin
            reg_write <= issue;
            if (issue) begin
                rd <= head.rd;
                write_data <= head.data;
                write_count <= write_count + 32'd1;
            end
        end
    end
    always_comb begin
        pending_mask = '0;
        for (int i = 0; i < DEPTH; i++) if (valid[i]) pending_mask[ent_rd[i]] = 1'b1;
        if (reg_write) pending_mask[rd] = 1'b1;
        pending_mask[0] = 1'b0;
    end
    assign empty = count == '0 && !reg_write;
endmodule

// File: tb/tb_reg_writeback.sv
// tb_reg_writeback: directed and randomized checks of reg_writeback against a queue-based reference model
module tb_reg_writeback;
    localparam int DEPTH = 4;
    logic clk = 1'b0, rst = 1'b0, flush = 1'b0;
    logic ld_valid = 1'b0, alu_valid = 1'b0;
    logic [4:0] ld_rd = '0, alu_rd = '0;
    logic [31:0] ld_data = '0, alu_data = '0;
    logic ld_ready, alu_ready, reg_write, empty;
    logic [4:0] rd;
    logic [31:0] write_data, pending_mask, write_count;

    reg_writeback #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data), .ld_ready(ld_ready),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .reg_write(reg_write), .rd(rd), .write_data(write_data),
        .pending_mask(pending_mask), .empty(empty), .write_count(write_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] rd;
        logic [31:0] data;
    } ent_t;
    ent_t q[$];
    logic m_we;
    logic [4:0] m_rd;
    logic [31:0] m_data, m_cnt;
    bit m_acc_ld, m_acc_alu;
    int n_cmp = 0, n_bad = 0, max_q = 0;

    function automatic logic [31:0] exp_mask();
        logic [31:0] m = '0;
        foreach (q[i]) m[q[i].rd] = 1'b1;
        if (m_we) m[m_rd] = 1'b1;
        m[0] = 1'b0;
        return m;
    endfunction

    task automatic model_reset();
        q.delete();
        m_we = 1'b0;
        m_rd = '0;
        m_data = '0;
        m_cnt = '0;
    endtask

    // one clock: the model applies the rules to the inputs present at the edge
    task automatic cycle();
        bit full;
        ent_t e;
        @(posedge clk);
        full = q.size() == DEPTH;
        m_acc_ld = ld_valid && !full && !flush;
        m_acc_alu = alu_valid && !full && !flush && !ld_valid;
        if (flush) begin
            q.delete();
            m_we = 1'b0;
        end else if (q.size() > 0) begin
            e = q.pop_front();
            m_we = 1'b1;
            m_rd = e.rd;
            m_data = e.data;
            m_cnt = m_cnt + 1;
        end else m_we = 1'b0;
        if (m_acc_ld && ld_rd != 0) q.push_back('{ld_rd, ld_data});
        else if (m_acc_alu && alu_rd != 0) q.push_back('{alu_rd, alu_data});
        if (q.size() > max_q) max_q = q.size();
        #1;
    endtask

    task automatic test_reset();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (reg_write !== 1'b0) begin n_bad++; $display("FAIL reset_reg_write got %b want 0", reg_write); end
        n_cmp++; if (rd !== 5'd0) begin n_bad++; $display("FAIL reset_rd got %0d want 0", rd); end
        n_cmp++; if (write_data !== 32'd0) begin n_bad++; $display("FAIL reset_write_data got %h want 0", write_data); end
        n_cmp++; if (write_count !== 32'd0) begin n_bad++; $display("FAIL reset_write_count got %0d want 0", write_count); end
        n_cmp++; if (pending_mask !== 32'd0) begin n_bad++; $display("FAIL reset_pending got %h want 0", pending_mask); end
        n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL reset_empty got %b want 1", empty); end
        rst = 1'b1;
        #1;
        n_cmp++; if (ld_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ld_ready got %b want 1", ld_ready); end
    endtask

    task automatic test_single_alu();
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h12345678;
        #1;
        n_cmp++; if (alu_ready !== 1'b1) begin n_bad++; $display("FAIL single_ready got %b want 1", alu_ready); end
        cycle();
        alu_valid = 1'b0;
        n_cmp++; if (reg_write !== 1'b0) begin n_bad++; $display("FAIL single_early_strobe got %b want 0", reg_write); end
        n_cmp++; if (pending_mask !== 32'h20) begin n_bad++; $display("FAIL single_pending_queued got %h want 00000020", pending_mask); end
        cycle();
        n_cmp++; if ({reg_write, rd, write_data} !== {1'b1, 5'd5, 32'h12345678}) begin n_bad++; $display("FAIL single_write got %b/%0d/%h want 1/5/12345678", reg_write, rd, write_data); end
        n_cmp++; if (write_count !== 32'd1) begin n_bad++; $display("FAIL single_count got %0d want 1", write_count); end
        n_cmp++; if (pending_mask !== 32'h20) begin n_bad++; $display("FAIL single_pending_issue got %h want 00000020", pending_mask); end
        cycle();
        n_cmp++; if (reg_write !== 1'b0) begin n_bad++; $display("FAIL single_one_cycle got %b want 0", reg_write); end
        n_cmp++; if (pending_mask !== 32'd0 || empty !== 1'b1) begin n_bad++; $display("FAIL single_idle got %h/%b want 0/1", pending_mask, empty); end
    endtask

    task automatic test_priority();
        ld_valid = 1'b1; ld_rd = 5'd3; ld_data = 32'hAAAA0000;
        alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'h0000BBBB;
        #1;
        n_cmp++; if ({ld_ready, alu_ready} !== 2'b10) begin n_bad++; $display("FAIL prio_readies got %b%b want 10", ld_ready, alu_ready); end
        cycle();
        ld_valid = 1'b0;
        #1;
        n_cmp++; if (alu_ready !== 1'b1) begin n_bad++; $display("FAIL prio_alu_next got %b want 1", alu_ready); end
        cycle();
        alu_valid = 1'b0;
        n_cmp++; if ({reg_write, rd, write_data} !== {1'b1, 5'd3, 32'hAAAA0000}) begin n_bad++; $display("FAIL prio_first got %b/%0d/%h want 1/3/aaaa0000", reg_write, rd, write_data); end
        cycle();
        n_cmp++; if ({reg_write, rd, write_data} !== {1'b1, 5'd4, 32'h0000BBBB}) begin n_bad++; $display("FAIL prio_second got %b/%0d/%h want 1/4/0000bbbb", reg_write, rd, write_data); end
        cycle();
        n_cmp++; if (write_count !== m_cnt) begin n_bad++; $display("FAIL prio_count got %0d want %0d", write_count, m_cnt); end
    endtask

    task automatic test_back_to_back();
        logic [4:0] sent[$], got[$];
        logic [31:0] base = write_count;
        max_q = 0;
        for (int k = 0; k < 5; k++) begin
            alu_valid = 1'b1; alu_rd = 5'(10 + k); alu_data = $urandom;
            #1;
            n_cmp++; if (alu_ready !== (q.size() != DEPTH)) begin n_bad++; $display("FAIL b2b_ready got %b at %0d queued", alu_ready, q.size()); end
            sent.push_back(alu_rd);
            cycle();
            if (reg_write) got.push_back(rd);
            n_cmp++; if (reg_write !== m_we || (m_we && write_data !== m_data)) begin n_bad++; $display("FAIL b2b_write got %b/%h want %b/%h", reg_write, write_data, m_we, m_data); end
        end
        alu_valid = 1'b0;
        repeat (3) begin
            cycle();
            if (reg_write) got.push_back(rd);
        end
        n_cmp++; if (got != sent) begin n_bad++; $display("FAIL b2b_order got %p want %p", got, sent); end
        n_cmp++; if (max_q > DEPTH) begin n_bad++; $display("FAIL b2b_occupancy got %0d want <= %0d", max_q, DEPTH); end
        n_cmp++; if (write_count !== base + 32'd5) begin n_bad++; $display("FAIL b2b_count got %0d want %0d", write_count, base + 32'd5); end
    endtask

    task automatic test_zero_reg();
        logic [31:0] base = write_count;
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hDEADBEEF;
        #1;
        n_cmp++; if (alu_ready !== 1'b1) begin n_bad++; $display("FAIL zero_ready got %b want 1", alu_ready); end
        cycle();
        alu_valid = 1'b0;
        n_cmp++; if (pending_mask !== 32'd0) begin n_bad++; $display("FAIL zero_pending got %h want 0", pending_mask); end
        repeat (2) begin
            cycle();
            n_cmp++; if (reg_write !== 1'b0) begin n_bad++; $display("FAIL zero_strobe got %b want 0", reg_write); end
        end
        n_cmp++; if (write_count !== base) begin n_bad++; $display("FAIL zero_count got %0d want %0d", write_count, base); end
    endtask

    task automatic test_flush();
        logic [31:0] base = write_count;
        alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h11111111;
        cycle();
        alu_rd = 5'd2; alu_data = 32'h22222222;
        cycle();
        n_cmp++; if ({reg_write, rd} !== {1'b1, 5'd1}) begin n_bad++; $display("FAIL flush_r1 got %b/%0d want 1/1", reg_write, rd); end
        flush = 1'b1; alu_rd = 5'd3; alu_data = 32'h33333333;
        #1;
        n_cmp++; if ({ld_ready, alu_ready} !== 2'b00) begin n_bad++; $display("FAIL flush_readies got %b%b want 00", ld_ready, alu_ready); end
        cycle();
        flush = 1'b0; alu_valid = 1'b0;
        n_cmp++; if ({reg_write, pending_mask, empty} !== {1'b0, 32'd0, 1'b1}) begin n_bad++; $display("FAIL flush_state got %b/%h/%b want 0/0/1", reg_write, pending_mask, empty); end
        repeat (2) begin
            cycle();
            n_cmp++; if (reg_write !== 1'b0) begin n_bad++; $display("FAIL flush_leak got %b/%0d want no write", reg_write, rd); end
        end
        n_cmp++; if (write_count !== base + 32'd1) begin n_bad++; $display("FAIL flush_count got %0d want %0d", write_count, base + 32'd1); end
    endtask

    task automatic test_async_reset();
        alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h77777777;
        cycle();
        alu_rd = 5'd8; alu_data = 32'h88888888;
        cycle();
        alu_valid = 1'b0;
        n_cmp++; if (reg_write !== 1'b1) begin n_bad++; $display("FAIL areset_pre got %b want 1", reg_write); end
        #2 rst = 1'b0;
        #1;
        model_reset();
        n_cmp++; if ({reg_write, pending_mask, write_count, empty} !== {1'b0, 32'd0, 32'd0, 1'b1}) begin n_bad++; $display("FAIL areset_now got %b/%h/%0d/%b want 0/0/0/1", reg_write, pending_mask, write_count, empty); end
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (3) begin
            cycle();
            n_cmp++; if (reg_write !== 1'b0 || write_count !== 32'd0) begin n_bad++; $display("FAIL areset_after got %b/%0d want 0/0", reg_write, write_count); end
        end
    endtask

    task automatic test_random();
        m_acc_ld = 1'b1;
        m_acc_alu = 1'b1;
        for (int n = 0; n < 300; n++) begin
            if (!ld_valid || m_acc_ld) begin
                ld_valid = $urandom_range(0, 2) == 0; ld_rd = 5'($urandom_range(0, 7)); ld_data = $urandom;
            end
            if (!alu_valid || m_acc_alu) begin
                alu_valid = $urandom_range(0, 1) == 1; alu_rd = 5'($urandom_range(0, 7)); alu_data = $urandom;
            end
            flush = $urandom_range(0, 15) == 0;
            #1;
            n_cmp++; if (ld_ready !== (q.size() != DEPTH && !flush)) begin n_bad++; $display("FAIL rnd_ld_ready cycle %0d got %b", n, ld_ready); end
            n_cmp++; if (alu_ready !== (q.size() != DEPTH && !flush && !ld_valid)) begin n_bad++; $display("FAIL rnd_alu_ready cycle %0d got %b", n, alu_ready); end
            n_cmp++; if (pending_mask !== exp_mask()) begin n_bad++; $display("FAIL rnd_pending cycle %0d got %h want %h", n, pending_mask, exp_mask()); end
            n_cmp++; if (empty !== (q.size() == 0 && !m_we)) begin n_bad++; $display("FAIL rnd_empty cycle %0d got %b", n, empty); end
            cycle();
            n_cmp++; if (reg_write !== m_we) begin n_bad++; $display("FAIL rnd_strobe cycle %0d got %b want %b", n, reg_write, m_we); end
            n_cmp++; if (rd !== m_rd || write_data !== m_data) begin n_bad++; $display("FAIL rnd_port cycle %0d got %0d/%h want %0d/%h", n, rd, write_data, m_rd, m_data); end
            n_cmp++; if (write_count !== m_cnt) begin n_bad++; $display("FAIL rnd_count cycle %0d got %0d want %0d", n, write_count, m_cnt); end
        end
        ld_valid = 1'b0; alu_valid = 1'b0; flush = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_alu();
        test_priority();
        test_back_to_back();
        test_zero_reg();
        test_flush();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
